// File: rtl/airlock_sequencer.sv
// Two-door airlock controller: arbitrates inside/outside transfer requests,
// sequences doors and pumps through a transfer, and latches a sticky fault
// on any timeout or door/pressure interlock violation.
module airlock_sequencer #(
  parameter int unsigned DOOR_HOLD    = 4,
  parameter int unsigned DOOR_TIMEOUT = 6,
  parameter int unsigned PUMP_TIMEOUT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic req_enter,
  input  logic req_exit,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Pressurized,
  input  logic Evacuated,
  output logic open_inner,
  output logic open_outer,
  output logic pressurize,
  output logic evacuate,
  output logic grant_enter,
  output logic grant_exit,
  output logic done,
  output logic fault
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DOOR_HOLD - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PUMP_LAST = CNT_W'(PUMP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OPEN_IN,
    S_CLOSE_IN,
    S_EVAC,
    S_OPEN_OUT,
    S_CLOSE_OUT,
    S_PRESS,
    S_FINISH,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    D_NONE,
    D_ENTER,
    D_EXIT,
    D_RECOVER
  } dir_e;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_exit_q, last_exit_d;

  logic open_inner_q, open_inner_d;
  logic open_outer_q, open_outer_d;
  logic pressurize_q, pressurize_d;
  logic evacuate_q, evacuate_d;
  logic grant_enter_q, grant_enter_d;
  logic grant_exit_q, grant_exit_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic doors_closed_c;
  logic pick_exit_c;

  assign doors_closed_c = InnerClosed && OuterClosed;
  // On a tie the requester not served last wins; last_exit_q resets to enter.
  assign pick_exit_c    = req_exit && (!req_enter || !last_exit_q);

  // State, counter, arbitration history and registered Moore outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      dir_q         <= D_NONE;
      cnt_q         <= '0;
      last_exit_q   <= 1'b0;
      open_inner_q  <= 1'b0;
      open_outer_q  <= 1'b0;
      pressurize_q  <= 1'b0;
      evacuate_q    <= 1'b0;
      grant_enter_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      cnt_q         <= cnt_d;
      last_exit_q   <= last_exit_d;
      open_inner_q  <= open_inner_d;
      open_outer_q  <= open_outer_d;
      pressurize_q  <= pressurize_d;
      evacuate_q    <= evacuate_d;
      grant_enter_q <= grant_enter_d;
      grant_exit_q  <= grant_exit_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state: interlocks first, then exit condition, then timeout.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_exit_d = last_exit_q;
    case (state_q)
      S_IDLE: begin
        if (doors_closed_c && Pressurized && (req_enter || req_exit)) begin
          if (pick_exit_c) begin
            dir_d   = D_EXIT;
            state_d = S_OPEN_IN;
          end else begin
            dir_d   = D_ENTER;
            state_d = S_EVAC;
          end
        end else if (doors_closed_c && !Pressurized) begin
          dir_d   = D_RECOVER;
          state_d = S_PRESS;
        end
      end
      S_OPEN_IN: begin
        if (!OuterClosed || !Pressurized) state_d = S_FAULT;
        else if (cnt_q == HOLD_LAST)      state_d = S_CLOSE_IN;
      end
      S_CLOSE_IN: begin
        if (InnerClosed)               state_d = (dir_q == D_EXIT) ? S_EVAC : S_FINISH;
        else if (cnt_q == DOOR_LAST)   state_d = S_FAULT;
      end
      S_EVAC: begin
        if (!doors_closed_c)           state_d = S_FAULT;
        else if (Evacuated)            state_d = S_OPEN_OUT;
        else if (cnt_q == PUMP_LAST)   state_d = S_FAULT;
      end
      S_OPEN_OUT: begin
        if (!InnerClosed || !Evacuated) state_d = S_FAULT;
        else if (cnt_q == HOLD_LAST)    state_d = S_CLOSE_OUT;
      end
      S_CLOSE_OUT: begin
        if (OuterClosed)               state_d = S_PRESS;
        else if (cnt_q == DOOR_LAST)   state_d = S_FAULT;
      end
      S_PRESS: begin
        if (!doors_closed_c) begin
          state_d = S_FAULT;
        end else if (Pressurized) begin
          case (dir_q)
            D_EXIT:  state_d = S_FINISH;
            D_ENTER: state_d = S_OPEN_IN;
            default: begin
              state_d = S_IDLE;
              dir_d   = D_NONE;
            end
          endcase
        end else if (cnt_q == PUMP_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_FINISH: begin
        last_exit_d = (dir_q == D_EXIT);
        dir_d       = D_NONE;
        state_d     = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output decode of the upcoming state so the registered outputs track state_q.
  always_comb begin
    open_inner_d  = 1'b0;
    open_outer_d  = 1'b0;
    pressurize_d  = 1'b0;
    evacuate_d    = 1'b0;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      S_OPEN_IN:  open_inner_d = 1'b1;
      S_OPEN_OUT: open_outer_d = 1'b1;
      S_EVAC:     evacuate_d   = 1'b1;
      S_PRESS:    pressurize_d = 1'b1;
      S_FINISH:   done_d       = 1'b1;
      S_FAULT:    fault_d      = 1'b1;
      default:    ;
    endcase
    grant_enter_d = (dir_d == D_ENTER) && (state_d != S_IDLE) && (state_d != S_FAULT);
    grant_exit_d  = (dir_d == D_EXIT)  && (state_d != S_IDLE) && (state_d != S_FAULT);
  end

  assign open_inner  = open_inner_q;
  assign open_outer  = open_outer_q;
  assign pressurize  = pressurize_q;
  assign evacuate    = evacuate_q;
  assign grant_enter = grant_enter_q;
  assign grant_exit  = grant_exit_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: a small chamber plant drives the sensors and a
// route-list reference model predicts every output each cycle.
module tb_airlock_sequencer;

  localparam int HOLD = 4;
  localparam int DTO  = 6;
  localparam int PTO  = 8;

  localparam int P_IDLE = 0, P_OPEN_IN = 1, P_CLOSE_IN = 2, P_EVAC = 3, P_OPEN_OUT = 4;
  localparam int P_CLOSE_OUT = 5, P_PRESS = 6, P_FINISH = 7, P_FAULT = 8;
  localparam int D_NONE = 0, D_ENTER = 1, D_EXIT = 2, D_REC = 3;

  logic Clock, Reset, req_enter, req_exit;
  logic InnerClosed, OuterClosed, Pressurized, Evacuated;
  logic open_inner, open_outer, pressurize, evacuate;
  logic grant_enter, grant_exit, done, fault;
  logic [7:0] dut_o;

  assign dut_o = {open_inner, open_outer, pressurize, evacuate,
                  grant_enter, grant_exit, done, fault};

  int vec = 0;
  int err = 0;

  airlock_sequencer #(
    .DOOR_HOLD(HOLD), .DOOR_TIMEOUT(DTO), .PUMP_TIMEOUT(PTO), .CNT_W(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .req_enter(req_enter), .req_exit(req_exit),
    .InnerClosed(InnerClosed), .OuterClosed(OuterClosed),
    .Pressurized(Pressurized), .Evacuated(Evacuated),
    .open_inner(open_inner), .open_outer(open_outer),
    .pressurize(pressurize), .evacuate(evacuate),
    .grant_enter(grant_enter), .grant_exit(grant_exit),
    .done(done), .fault(fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- chamber plant ----------------
  int door_delay = 1, pump_delay = 2;
  int in_cnt = 0, out_cnt = 0, ev_cnt = 0, pr_cnt = 0;
  bit ev_stuck = 0, force_inner_open = 0;

  task automatic plant();
    if (open_inner === 1'b1) begin InnerClosed = 1'b0; in_cnt = door_delay; end
    else if (!InnerClosed) begin
      if (in_cnt <= 0) InnerClosed = 1'b1; else in_cnt--;
    end
    if (force_inner_open) InnerClosed = 1'b0;
    if (open_outer === 1'b1) begin OuterClosed = 1'b0; out_cnt = door_delay; end
    else if (!OuterClosed) begin
      if (out_cnt <= 0) OuterClosed = 1'b1; else out_cnt--;
    end
    if (evacuate === 1'b1) begin
      Pressurized = 1'b0;
      if (!ev_stuck) begin
        if (ev_cnt <= 0) Evacuated = 1'b1; else ev_cnt--;
      end
    end else ev_cnt = pump_delay;
    if (pressurize === 1'b1) begin
      Evacuated = 1'b0;
      if (pr_cnt <= 0) Pressurized = 1'b1; else pr_cnt--;
    end else pr_cnt = pump_delay;
  endtask

  // ---------------- reference model ----------------
  int m_ph = P_IDLE, m_age = 0, m_dir = D_NONE;
  bit m_last_exit = 0;
  int m_route[$];

  function automatic bit m_bad(int ph);
    case (ph)
      P_OPEN_IN:       return !OuterClosed || !Pressurized;
      P_OPEN_OUT:      return !InnerClosed || !Evacuated;
      P_EVAC, P_PRESS: return !InnerClosed || !OuterClosed;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic bit m_ready(int ph);
    case (ph)
      P_OPEN_IN, P_OPEN_OUT: return m_age == HOLD - 1;
      P_CLOSE_IN:  return InnerClosed;
      P_CLOSE_OUT: return OuterClosed;
      P_EVAC:      return Evacuated;
      P_PRESS:     return Pressurized;
      P_FINISH:    return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic int m_limit(int ph);
    case (ph)
      P_CLOSE_IN, P_CLOSE_OUT: return DTO;
      P_EVAC, P_PRESS:         return PTO;
      default:                 return 0;
    endcase
  endfunction

  task automatic m_advance();
    if (m_route.size() == 0) begin m_ph = P_IDLE; m_dir = D_NONE; end
    else m_ph = m_route.pop_front();
    m_age = 0;
  endtask

  task automatic m_clock();
    bit take_exit;
    if (!Reset) begin
      m_ph = P_IDLE; m_age = 0; m_dir = D_NONE; m_last_exit = 0; m_route.delete();
    end else if (m_ph == P_IDLE) begin
      if (InnerClosed && OuterClosed && Pressurized && (req_enter || req_exit)) begin
        take_exit = req_exit && !(req_enter && m_last_exit);
        if (take_exit) begin
          m_dir = D_EXIT;
          m_route = '{P_OPEN_IN, P_CLOSE_IN, P_EVAC, P_OPEN_OUT, P_CLOSE_OUT, P_PRESS, P_FINISH};
        end else begin
          m_dir = D_ENTER;
          m_route = '{P_EVAC, P_OPEN_OUT, P_CLOSE_OUT, P_PRESS, P_OPEN_IN, P_CLOSE_IN, P_FINISH};
        end
        m_advance();
      end else if (InnerClosed && OuterClosed && !Pressurized) begin
        m_dir = D_REC;
        m_route = '{P_PRESS};
        m_advance();
      end
    end else if (m_ph == P_FAULT) begin
      m_age++;
    end else if (m_bad(m_ph)) begin
      m_ph = P_FAULT; m_route.delete();
    end else if (m_ready(m_ph)) begin
      if (m_ph == P_FINISH) m_last_exit = (m_dir == D_EXIT);
      m_advance();
    end else if (m_limit(m_ph) != 0 && m_age == m_limit(m_ph) - 1) begin
      m_ph = P_FAULT; m_route.delete();
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [7:0] m_expect();
    logic gr;
    gr = (m_ph != P_IDLE) && (m_ph != P_FAULT);
    return {m_ph == P_OPEN_IN, m_ph == P_OPEN_OUT, m_ph == P_PRESS, m_ph == P_EVAC,
            gr && (m_dir == D_ENTER), gr && (m_dir == D_EXIT),
            m_ph == P_FINISH, m_ph == P_FAULT};
  endfunction

  // One clock: plant reacts, model steps on the same inputs, sample after the edge.
  task automatic tick();
    plant();
    m_clock();
    @(posedge Clock);
    #1;
  endtask

  task automatic start(input bit rx, input bit re, input bit pr_ok);
    Reset = 1'b0; req_exit = rx; req_enter = re;
    InnerClosed = 1'b1; OuterClosed = 1'b1; Pressurized = pr_ok; Evacuated = 1'b0;
    ev_stuck = 0; force_inner_open = 0; in_cnt = 0; out_cnt = 0;
    ev_cnt = pump_delay; pr_cnt = pump_delay;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0; req_enter = 1'b1; req_exit = 1'b1;
    InnerClosed = 1'b1; OuterClosed = 1'b1; Pressurized = 1'b1; Evacuated = 1'b0;
    repeat (3) begin
      tick();
      vec++;
      if (dut_o !== 8'h00 || dut_o !== m_expect()) begin
        err++; $display("FAIL reset got %b want %b", dut_o, 8'h00);
      end
    end
  endtask

  task automatic test_exit_transfer();
    int oi, oo, dn;
    door_delay = 1; pump_delay = 2;
    start(1'b1, 1'b0, 1'b1);
    tick();
    vec++;
    if (grant_exit !== 1'b1) begin err++; $display("FAIL exit_grant got %b want 1", grant_exit); end
    req_exit = 1'b0;
    oi = int'(open_inner); oo = 0; dn = 0;
    repeat (40) begin
      tick();
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL exit_xfer t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      oi += int'(open_inner); oo += int'(open_outer); dn += int'(done);
    end
    vec++;
    if (oi != HOLD || oo != HOLD || dn != 1 || dut_o !== 8'h00) begin
      err++; $display("FAIL exit_summary got oi=%0d oo=%0d done=%0d o=%b want 4 4 1 00000000", oi, oo, dn, dut_o);
    end
  endtask

  task automatic test_tie_rotation();
    int order[$];
    int want[3];
    bit prev_g, g;
    want = '{1, 0, 1};
    prev_g = 0;
    door_delay = 1; pump_delay = 2;
    start(1'b1, 1'b1, 1'b1);
    repeat (160) begin
      tick();
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL tie t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      g = grant_enter || grant_exit;
      if (g && !prev_g) order.push_back(grant_exit ? 1 : 0);
      prev_g = g;
    end
    req_enter = 1'b0; req_exit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (order.size() <= i) begin
        err++; $display("FAIL tie_order[%0d] got none want %0d", i, want[i]);
      end else if (order[i] != want[i]) begin
        err++; $display("FAIL tie_order[%0d] got %0d want %0d", i, order[i], want[i]);
      end
    end
  endtask

  task automatic test_recover();
    int pz;
    bit saw_done, saw_grant;
    pz = 0; saw_done = 0; saw_grant = 0;
    door_delay = 1; pump_delay = 3;
    start(1'b0, 1'b0, 1'b0);
    repeat (20) begin
      tick();
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL recover t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      pz += int'(pressurize);
      saw_done |= done; saw_grant |= (grant_enter | grant_exit);
    end
    vec++;
    if (pz != 4 || saw_done || saw_grant || dut_o !== 8'h00) begin
      err++; $display("FAIL recover_summary got pz=%0d done=%0b grant=%0b o=%b want 4 0 0 00000000",
                      pz, saw_done, saw_grant, dut_o);
    end
  endtask

  task automatic test_evac_timeout();
    int ev;
    ev = 0;
    door_delay = 1; pump_delay = 2;
    start(1'b0, 1'b1, 1'b1);
    ev_stuck = 1;
    repeat (25) begin
      tick();
      req_enter = 1'b0;
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL evac_to t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      ev += int'(evacuate);
    end
    vec++;
    if (ev != PTO || dut_o !== 8'h01) begin
      err++; $display("FAIL evac_to_summary got ev=%0d o=%b want 8 00000001", ev, dut_o);
    end
    Reset = 1'b0;
    tick();
    vec++;
    if (dut_o !== 8'h00) begin err++; $display("FAIL fault_clear got %b want 00000000", dut_o); end
    Reset = 1'b1;
  endtask

  task automatic test_open_out_interlock();
    bit found;
    found = 0;
    door_delay = 0; pump_delay = 1;
    start(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      req_exit = 1'b0;
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL ilk_wait t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      found = (open_outer === 1'b1);
    end
    vec++;
    if (!found) begin err++; $display("FAIL ilk_reach got no open_outer want open_outer=1"); end
    force_inner_open = 1;
    tick();
    vec++;
    if (dut_o !== 8'h01 || dut_o !== m_expect()) begin
      err++; $display("FAIL ilk_fault got %b want 00000001", dut_o);
    end
    force_inner_open = 0;
    repeat (3) begin
      tick();
      vec++;
      if (fault !== 1'b1) begin err++; $display("FAIL ilk_sticky got %b want 1", fault); end
    end
  endtask

  task automatic test_last_cycle_and_midreset();
    int ev;
    bit found;
    ev = 0; found = 0;
    door_delay = 0; pump_delay = 7;
    start(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      req_enter = 1'b0;
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL lastcyc t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      ev += int'(evacuate);
      found = (open_outer === 1'b1);
    end
    vec++;
    if (!found || ev != PTO || fault !== 1'b0) begin
      err++; $display("FAIL lastcyc_summary got found=%0b ev=%0d fault=%b want 1 8 0", found, ev, fault);
    end
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL to_open_in t=%0t got %b want %b", $time, dut_o, m_expect());
      end
      found = (open_inner === 1'b1);
    end
    vec++;
    if (!found) begin err++; $display("FAIL open_in_reach got no open_inner want open_inner=1"); end
    Reset = 1'b0;
    tick();
    vec++;
    if (open_inner !== 1'b0 || dut_o !== m_expect()) begin
      err++; $display("FAIL midreset got %b want %b", dut_o, m_expect());
    end
    Reset = 1'b1;
  endtask

  task automatic test_random();
    door_delay = 1; pump_delay = 2;
    start(1'b0, 1'b0, 1'b1);
    repeat (3000) begin
      if ($urandom_range(0, 149) == 0 || (m_ph == P_FAULT && $urandom_range(0, 7) == 0)) begin
        Reset = 1'b0;
        door_delay = $urandom_range(0, 6);
        pump_delay = $urandom_range(0, 9);
        ev_stuck = ($urandom_range(0, 5) == 0);
        force_inner_open = 0;
      end else begin
        Reset = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) req_enter = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) req_exit = 1'($urandom_range(0, 1));
      if (force_inner_open) force_inner_open = ($urandom_range(0, 2) != 0);
      else                  force_inner_open = ($urandom_range(0, 299) == 0);
      tick();
      vec++;
      if (dut_o !== m_expect()) begin
        err++; $display("FAIL random t=%0t got %b want %b", $time, dut_o, m_expect());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exit_transfer();
    test_tie_rotation();
    test_recover();
    test_evac_timeout();
    test_open_out_interlock();
    test_last_cycle_and_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
